// File: rtl/fp_alu_driver.sv
`default_nettype none
// ============================================================================
// Module      : fp_alu_driver
// Description : Command/response wrapper around a combinational fp_alu.
//               Latches operands, holds them on the ALU for SETTLE_CYCLES,
//               captures result and flags, and returns them on a valid/ready
//               response channel. Keeps sticky overflow/underflow flags and a
//               count of successful operations.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_alu_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_selop,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_selop,
    input  logic [31:0]      alu_result,
    input  logic             alu_parity,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [2:0] C_SEL_ILLEGAL = 3'b111;
    // Settle counter counts down to zero; zero marks the final DRIVE cycle.
    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_settle;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_selop;
    logic [31:0]      r_result;
    logic [2:0]       r_flags;
    logic             r_err;
    logic             r_sticky_ovf;
    logic             r_sticky_unf;
    logic [CNT_W-1:0] r_count;

    logic             w_capture;
    logic             w_rsp_fire;

    assign w_capture  = (r_state == S_DRIVE) && (r_settle == 4'd0);
    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_selop  = r_selop;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_err    = r_err;
    assign sticky_ovf = r_sticky_ovf;
    assign sticky_unf = r_sticky_unf;
    assign op_count   = r_count;

    // Sequencer: accept command, hold operands during settle, capture, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_settle <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_selop  <= 3'd0;
            r_result <= 32'd0;
            r_flags  <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_selop == C_SEL_ILLEGAL) begin
                            // Rejected command never reaches the ALU.
                            r_result <= 32'd0;
                            r_flags  <= 3'd0;
                            r_err    <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_a      <= cmd_a;
                            r_b      <= cmd_b;
                            r_selop  <= cmd_selop;
                            r_settle <= C_SETTLE_LOAD;
                            r_state  <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_settle == 4'd0) begin
                        r_result <= alu_result;
                        r_flags  <= {alu_parity, alu_overflow, alu_underflow};
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a capture that sees the flag wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
        end else begin
            if (w_capture && alu_overflow) begin
                r_sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky_ovf <= 1'b0;
            end
            if (w_capture && alu_underflow) begin
                r_sticky_unf <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky_unf <= 1'b0;
            end
        end
    end

    // Completed-operation counter, advances on accepted non-error responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_rsp_fire && !r_err) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_alu_driver
// Description : Scoreboard bench for fp_alu_driver with a bench-driven ALU
//               stub. Instance u_dut: SETTLE_CYCLES=1, CNT_W=4. Instance
//               u_dut3: SETTLE_CYCLES=3, CNT_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_alu_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance 1 signals ----------------
    logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]  cmd_selop, alu_selop, rsp_flags, stub_flags;
    logic        clr_sticky, sticky_ovf, sticky_unf;
    logic [3:0]  op_count;

    // ---------------- instance 3 signals ----------------
    logic        rst3, cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [31:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
    logic [2:0]  cmd_selop3, alu_selop3, rsp_flags3, stub_flags3;
    logic        clr_sticky3, sticky_ovf3, sticky_unf3;
    logic [15:0] op_count3;

    fp_alu_driver #(.SETTLE_CYCLES(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_selop(cmd_selop),
        .alu_a(alu_a), .alu_b(alu_b), .alu_selop(alu_selop),
        .alu_result(alu_result), .alu_parity(stub_flags[2]),
        .alu_overflow(stub_flags[1]), .alu_underflow(stub_flags[0]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .op_count(op_count)
    );

    fp_alu_driver #(.SETTLE_CYCLES(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_selop(cmd_selop3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_selop(alu_selop3),
        .alu_result(alu_result3), .alu_parity(stub_flags3[2]),
        .alu_overflow(stub_flags3[1]), .alu_underflow(stub_flags3[0]),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_flags(rsp_flags3), .rsp_err(rsp_err3), .clr_sticky(clr_sticky3),
        .sticky_ovf(sticky_ovf3), .sticky_unf(sticky_unf3), .op_count(op_count3)
    );

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [3:0]  m_cnt;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command through instance 1: drive, push expectation, wait for the
    // response, optionally stall, pop and compare on handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel,
                         input logic [31:0] res, input logic [2:0] fl,
                         input int stall, input logic clr_cap);
        exp_t e;
        exp_t got_e;
        int lat;
        int exp_lat;
        logic [31:0] hold_res;
        logic [2:0]  hold_fl;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_selop = sel;
        alu_result = res; stub_flags = fl;
        e.err = (sel == 3'b111);
        e.res = e.err ? 32'd0 : res;
        e.fl  = e.err ? 3'd0 : fl;
        sb.push_back(e);
        exp_lat = e.err ? 1 : 2;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom; cmd_selop = 3'd0;
        if (!e.err) begin m_a = a; m_b = b; m_sel = sel; end
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_selop", {29'd0, alu_selop}, {29'd0, m_sel});
        if (clr_cap) clr_sticky = 1'b1;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            clr_sticky = 1'b0;
            lat++;
        end
        clr_sticky = 1'b0;
        chk("latency", lat, exp_lat);
        hold_res = rsp_result; hold_fl = rsp_flags;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_a = $urandom; cmd_b = $urandom; cmd_selop = 3'd2;
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("stall_result", rsp_result, hold_res);
            chk("stall_flags", {29'd0, rsp_flags}, {29'd0, hold_fl});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        got_e = sb.pop_front();
        chk("rsp_result", rsp_result, got_e.res);
        chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, got_e.fl});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, got_e.err});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (!got_e.err) m_cnt = m_cnt + 4'd1;
        chk("op_count", {28'd0, op_count}, {28'd0, m_cnt});
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("alu_a_held", alu_a, m_a);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_op_count", {28'd0, op_count}, 32'd0);
        chk("rst_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);
        m_cnt = 4'd0; m_a = 32'd0; m_b = 32'd0; m_sel = 3'd0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_selop = 3'd0;
        alu_result = 32'd0; stub_flags = 3'd0; rsp_ready = 1'b0; clr_sticky = 1'b0;
        rst3 = 1'b1; cmd_valid3 = 1'b0; cmd_a3 = 32'd0; cmd_b3 = 32'd0; cmd_selop3 = 3'd0;
        alu_result3 = 32'd0; stub_flags3 = 3'd0; rsp_ready3 = 1'b0; clr_sticky3 = 1'b0;
        #12;
        reset_dut();
        @(negedge clk);
        rst3 = 1'b0;

        // Basic add-like op, then illegal selop, then overflow capture.
        do_op(32'h40400000, 32'h40000000, 3'b000, 32'h40A00000, 3'b000, 0, 1'b0);
        chk("count_first", {28'd0, op_count}, 32'd1);
        do_op(32'h11111111, 32'h22222222, 3'b111, 32'hDEADBEEF, 3'b111, 0, 1'b0);
        do_op(32'h7F000000, 32'h7F000000, 3'b001, 32'h7F800000, 3'b010, 0, 1'b0);
        chk("sticky_ovf_set", {31'd0, sticky_ovf}, 32'd1);
        chk("sticky_unf_clear", {31'd0, sticky_unf}, 32'd0);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("sticky_ovf_cleared", {31'd0, sticky_ovf}, 32'd0);
        // Clear coincident with an overflow capture keeps the flag set.
        do_op(32'h7F7FFFFF, 32'h40000000, 3'b010, 32'h7F800000, 3'b010, 0, 1'b1);
        chk("sticky_ovf_coincident", {31'd0, sticky_ovf}, 32'd1);
        // Back-pressure with ignored command pulses, underflow + parity.
        do_op(32'h00800000, 32'h3F000000, 3'b011, 32'h00000000, 3'b101, 5, 1'b0);
        chk("sticky_unf_set", {31'd0, sticky_unf}, 32'd1);

        // Counter wrap on the 4-bit build: 16 successful ops return to zero.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            do_op($urandom, $urandom, 3'($urandom_range(0, 6)), $urandom,
                  3'($urandom_range(0, 7)), 0, 1'b0);
        end
        chk("count_wrap", {28'd0, op_count}, 32'd0);

        // SETTLE_CYCLES=3 instance: reset while in DRIVE discards the command.
        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_a3 = 32'h3F800000; cmd_b3 = 32'h3F800000; cmd_selop3 = 3'd0;
        alu_result3 = 32'h40000000;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(posedge clk); #1;
        chk("d3_in_drive", {31'd0, cmd_ready3}, 32'd0);
        #2 rst3 = 1'b1;
        #1;
        chk("d3_rst_rsp_valid", {31'd0, rsp_valid3}, 32'd0);
        chk("d3_rst_cmd_ready", {31'd0, cmd_ready3}, 32'd1);
        chk("d3_rst_op_count", {16'd0, op_count3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        // Stub value changes mid-DRIVE; the one at the final edge is captured.
        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_a3 = 32'h40400000; cmd_b3 = 32'h40400000; cmd_selop3 = 3'd1;
        alu_result3 = 32'hAAAA0001; stub_flags3 = 3'b000;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(posedge clk); #1;
        alu_result3 = 32'hBBBB0002;
        @(posedge clk); #1;
        chk("d3_not_yet", {31'd0, rsp_valid3}, 32'd0);
        alu_result3 = 32'hCCCC0003; stub_flags3 = 3'b001;
        @(posedge clk); #1;
        chk("d3_rsp_valid", {31'd0, rsp_valid3}, 32'd1);
        chk("d3_result", rsp_result3, 32'hCCCC0003);
        chk("d3_flags", {29'd0, rsp_flags3}, 32'd1);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        chk("d3_op_count", {16'd0, op_count3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
